// File: rtl/mux_pkg.sv
// Shared types and constants for the registered N:1 multiplexer.
//   state_t     : controller state (IDLE, SCAN)
//   MODE_MANUAL : mode input value selecting manual select
//   MODE_SCAN   : mode input value selecting auto-scan
package mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_nto1_comb.sv
// Purely combinational N:1 channel selector.
// Ports:
//   in_bus : flattened channel inputs, channel k = in_bus[k*WIDTH +: WIDTH]
//   sel    : channel index
//   data_c : selected channel data, zero when sel >= CHANNELS
module mux_nto1_comb #(
  parameter  int unsigned WIDTH    = 4,
  parameter  int unsigned CHANNELS = 16,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          data_c
);

  // Unmatched (out-of-range) indices fall through to the zero default.
  always_comb begin
    data_c = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (sel == SEL_W'(k)) data_c = in_bus[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_nto1_seq.sv
// Registered N:1 multiplexer with manual select and auto-scan modes.
// Optional feature macro: MUX_PARITY_EN adds out_parity (= ^out_data, registered).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_bus      : flattened channel inputs, sampled live at the load edge
//   sel_in      : manual channel select
//   mode        : 0 manual, 1 scan (latched at scan start)
//   start       : scan start request, honoured in IDLE with a free load slot
//   out_data    : registered selected data
//   out_sel     : channel index of out_data
//   out_valid   : output valid; consumer accepts on out_valid && out_ready
//   out_ready   : consumer ready
//   busy        : high while scanning
//   done        : one-cycle pulse after the last scan beat is accepted
//   out_parity  : (MUX_PARITY_EN only) parity of out_data
module mux_nto1_seq
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH    = 4,
  parameter  int unsigned CHANNELS = 16,
  localparam int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      mode,
  input  logic                      start,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done
`ifdef MUX_PARITY_EN
  ,
  output logic                      out_parity
`endif
);

  // Counter must reach CHANNELS itself to mark "last beat on the output".
  localparam int unsigned CNT_W = $clog2(CHANNELS + 1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_data, w_data_nxt;
  logic [SEL_W-1:0]   r_sel, w_sel_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic [SEL_W-1:0]   w_mux_sel;
  logic [WIDTH-1:0]   w_mux_data;
  logic               w_load;
  logic               w_accept;
  logic               w_last;

  assign w_load   = !r_valid || out_ready;
  assign w_accept = r_valid && out_ready;
  assign w_last   = (r_cnt == CNT_W'(CHANNELS));

  // Single selector shared by both modes; a scan start always fetches channel 0.
  always_comb begin
    if (r_state == SCAN)        w_mux_sel = SEL_W'(r_cnt);
    else if (mode == MODE_SCAN) w_mux_sel = '0;
    else                        w_mux_sel = sel_in;
  end

  mux_nto1_comb #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) u_sel (
    .in_bus (in_bus),
    .sel    (w_mux_sel),
    .data_c (w_mux_data)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_sel   <= w_sel_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == IDLE) begin
      if (mode == MODE_SCAN && start && w_load) w_state_nxt = SCAN;
    end else begin
      if (w_accept && w_last) w_state_nxt = IDLE;
    end
  end

  // Output/counter next values; everything holds unless a load slot is used.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = r_data;
    w_sel_nxt   = r_sel;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    if (r_state == IDLE) begin
      if (w_load) begin
        if (mode == MODE_MANUAL) begin
          w_data_nxt  = w_mux_data;
          w_sel_nxt   = sel_in;
          w_valid_nxt = 1'b1;
        end else if (start) begin
          w_data_nxt  = w_mux_data;
          w_sel_nxt   = '0;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_valid_nxt = 1'b0;
        end
      end
    end else begin
      if (w_accept) begin
        if (!w_last) begin
          w_data_nxt = w_mux_data;
          w_sel_nxt  = SEL_W'(r_cnt);
          w_cnt_nxt  = r_cnt + CNT_W'(1);
        end else begin
          w_valid_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
    end
  end

  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

`ifdef MUX_PARITY_EN
  // Tracks out_data exactly: a held data word keeps its parity.
  logic r_parity;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_parity <= 1'b0;
    else        r_parity <= ^w_data_nxt;
  end
  assign out_parity = r_parity;
`endif

endmodule
